// File: rtl/mem_line_responder_pkg.sv
// Shared types and constants for the line-granular backing memory.
// The default line geometry used by the responder and its bench.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RD_BURST,
    WR_BURST
  } state_t;

  localparam int LINE_WORDS_DEF = 4;
  localparam int OFFSET_BITS = $clog2(LINE_WORDS_DEF);
  localparam int BYTE_BITS = 2;

endpackage

// File: rtl/mem_line_responder_if.sv
// Request, write-beat and read-beat channels of the line responder.
// The cache side drives master, the responder sits on slave.
interface mem_line_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS_WIDTH = 16
);

  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic                     wdata_valid;
  logic [DATA_WIDTH-1:0]    wdata;
  logic                     wdata_ready;
  logic                     rdata_valid;
  logic [DATA_WIDTH-1:0]    rdata;
  logic                     rdata_last;
  logic                     rdata_ready;
  logic                     busy;

  modport master (
    output req_valid, req_write, req_addr,
    output wdata_valid, wdata, rdata_ready,
    input  req_ready, wdata_ready, busy,
    input  rdata_valid, rdata, rdata_last
  );

  modport slave (
    input  req_valid, req_write, req_addr,
    input  wdata_valid, wdata, rdata_ready,
    output req_ready, wdata_ready, busy,
    output rdata_valid, rdata, rdata_last
  );

endinterface

// File: rtl/mem_line_responder_array.sv
// Word store: asynchronous read port, synchronous write port.
// Contents are never reset.
module mem_resp_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 16384
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0]    i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0]    o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_line_responder.sv
// Line responder: fixed-latency refill bursts, beat-wise write-back.
// MEM_RESP_CRITICAL_WORD_FIRST_EN: reads start at the requested word.
module mem_line_responder
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS_WIDTH = 16,
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int READ_LATENCY = 3
) (
  input logic clk,
  input logic rst,
  mem_line_responder_if.slave bus
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = ADDRESS_WIDTH - BYTE_BITS;
  localparam int LINE_W = IDX_W - OFF_W;
  localparam int LAT_W = $clog2(READ_LATENCY + 2);
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  state_t                r_state, w_state;
  logic [LAT_W-1:0]      r_lat, w_lat;
  logic [LINE_W-1:0]     r_line, w_line;
  logic [OFF_W-1:0]      r_off, w_off;
  logic [OFF_W-1:0]      r_cnt, w_cnt;
  logic                  r_rvalid, w_rvalid;
  logic                  r_rlast, w_rlast;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdata;
  logic [DATA_WIDTH-1:0] w_q;
  logic                  w_load;
  logic                  w_we;
  logic [LINE_W-1:0]     w_req_line;
  logic [OFF_W-1:0]      w_req_off;
  logic [OFF_W-1:0]      w_start;
  logic [IDX_W-1:0]      w_raddr;
  logic                  w_unused;

  assign w_req_line = bus.req_addr[ADDRESS_WIDTH-1:OFF_W+BYTE_BITS];
  assign w_req_off  = bus.req_addr[OFF_W+BYTE_BITS-1:BYTE_BITS];

`ifdef MEM_RESP_CRITICAL_WORD_FIRST_EN
  assign w_start = w_req_off;
`else
  assign w_start = '0;
`endif

  assign w_unused = ^{bus.req_addr[BYTE_BITS-1:0], w_req_off};

  // Zero-latency reads fetch straight from the request address
  assign w_raddr = (r_state == IDLE) ? {w_req_line, w_start}
                                     : {r_line, r_off};

  mem_resp_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (2 ** IDX_W)
  ) u_array (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr({r_line, r_off}),
    .i_wdata(bus.wdata),
    .i_raddr(w_raddr),
    .o_rdata(w_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state;
  end

  always_comb begin
    w_state  = r_state;
    w_lat    = r_lat;
    w_line   = r_line;
    w_off    = r_off;
    w_cnt    = r_cnt;
    w_rvalid = r_rvalid;
    w_rdata  = r_rdata;
    w_rlast  = r_rlast;
    w_load   = 1'b0;
    w_we     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_line = w_req_line;
          w_cnt  = '0;
          if (bus.req_write) begin
            w_state = WR_BURST;
            w_off   = '0;
          end else begin
            w_off = w_start;
            if (READ_LATENCY == 0) begin
              w_state = RD_BURST;
              w_load  = 1'b1;
            end else begin
              w_state = WAIT;
              w_lat   = LAT_W'(READ_LATENCY);
            end
          end
        end
      end
      WAIT: begin
        if (r_lat <= LAT_W'(1)) begin
          w_state = RD_BURST;
          w_lat   = '0;
          w_load  = 1'b1;
        end else begin
          w_lat = r_lat - 1'b1;
        end
      end
      RD_BURST: begin
        if (r_rvalid && bus.rdata_ready) begin
          if (r_rlast) begin
            w_state  = IDLE;
            w_rvalid = 1'b0;
            w_rlast  = 1'b0;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      WR_BURST: begin
        if (bus.wdata_valid) begin
          w_we  = 1'b1;
          w_off = r_off + 1'b1;
          w_cnt = r_cnt + 1'b1;
          if (r_cnt == LAST_BEAT) w_state = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
    if (w_load) begin
      w_rdata  = w_q;
      w_rvalid = 1'b1;
      w_rlast  = (w_cnt == LAST_BEAT);
      w_off    = w_off + 1'b1;
      w_cnt    = w_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lat    <= '0;
      r_line   <= '0;
      r_off    <= '0;
      r_cnt    <= '0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rlast  <= 1'b0;
    end else begin
      r_lat    <= w_lat;
      r_line   <= w_line;
      r_off    <= w_off;
      r_cnt    <= w_cnt;
      r_rvalid <= w_rvalid;
      r_rdata  <= w_rdata;
      r_rlast  <= w_rlast;
    end
  end

  assign bus.req_ready   = (r_state == IDLE);
  assign bus.busy        = (r_state != IDLE);
  assign bus.wdata_ready = (r_state == WR_BURST);
  assign bus.rdata_valid = r_rvalid;
  assign bus.rdata       = r_rdata;
  assign bus.rdata_last  = r_rlast;

endmodule

// File: tb/tb_mem_line_responder.sv
// Bench for mem_line_responder: reference model plus directed cases.
// Also exercises a zero-latency instance.
module tb_mem_line_responder;
  import mem_pkg::*;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int LW = LINE_WORDS_DEF;
  localparam int RL = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_line_responder_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) ifa ();
  mem_line_responder_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) ifz ();

  mem_line_responder #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
    .LINE_WORDS(LW), .READ_LATENCY(RL)
  ) u_dut (.clk(clk), .rst(rst), .bus(ifa));

  mem_line_responder #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
    .LINE_WORDS(LW), .READ_LATENCY(0)
  ) u_dut0 (.clk(clk), .rst(rst), .bus(ifz));

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: word store, pending read beats, write progress
  logic [31:0] m_mem [int];
  logic [32:0] m_q [$];
  int m_mode = 0;
  int m_first = 0;
  int m_wbase = 0;
  int m_wn = 0;
  bit w_lines [int];

  function automatic int start_of(logic [15:0] a);
`ifdef MEM_RESP_CRITICAL_WORD_FIRST_EN
    return int'(a >> 2) % LW;
`else
    return 0;
`endif
  endfunction

  always @(negedge clk) begin
    int md;
    if (rst) begin
      chk("rst_req_ready", ifa.req_ready, 1);
      chk("rst_busy", ifa.busy, 0);
      chk("rst_wdata_ready", ifa.wdata_ready, 0);
      chk("rst_rdata_valid", ifa.rdata_valid, 0);
      chk("rst_rdata", ifa.rdata, 0);
      chk("rst_rdata_last", ifa.rdata_last, 0);
      m_mode = 0;
      m_q.delete();
    end else begin
      md = m_mode;
      chk("req_ready", ifa.req_ready, md == 0);
      chk("busy", ifa.busy, md != 0);
      chk("wdata_ready", ifa.wdata_ready, md == 2);
      if (md == 1) begin
        chk("rdata_valid", ifa.rdata_valid, cyc >= m_first);
        if (ifa.rdata_valid && m_q.size() > 0) begin
          chk("rdata", ifa.rdata, m_q[0][31:0]);
          chk("rdata_last", ifa.rdata_last, m_q[0][32]);
          if (ifa.rdata_ready) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_mode = 0;
          end
        end
      end else begin
        chk("rdata_valid_off", ifa.rdata_valid, 0);
      end
      if (md == 2 && ifa.wdata_valid) begin
        m_mem[m_wbase + m_wn] = ifa.wdata;
        m_wn++;
        if (m_wn == LW) m_mode = 0;
      end
      if (md == 0 && ifa.req_valid) begin
        int base;
        int st;
        base = int'(ifa.req_addr >> 4) * LW;
        if (ifa.req_write) begin
          m_mode = 2;
          m_wbase = base;
          m_wn = 0;
        end else begin
          st = start_of(ifa.req_addr);
          for (int k = 0; k < LW; k++) begin
            int ix;
            logic [31:0] v;
            ix = base + ((st + k) % LW);
            v = m_mem.exists(ix) ? m_mem[ix] : 32'h0;
            m_q.push_back({k == LW - 1, v});
          end
          m_mode = 1;
          m_first = cyc + 1 + RL;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(string nm);
    int n;
    n = 0;
    while (!ifa.req_ready && n < 200) begin
      step();
      n++;
    end
    chk(nm, ifa.req_ready, 1);
  endtask

  task automatic write_line(logic [15:0] a,
                            logic [LW-1:0][31:0] d, bit gaps);
    wait_idle("wr_idle");
    ifa.req_valid = 1'b1;
    ifa.req_write = 1'b1;
    ifa.req_addr = a;
    step();
    ifa.req_valid = 1'b0;
    for (int k = 0; k < LW; k++) begin
      int n;
      n = 0;
      ifa.wdata_valid = 1'b0;
      while (gaps && $urandom_range(0, 2) == 0 && n < 5) begin
        step();
        n++;
      end
      ifa.wdata_valid = 1'b1;
      ifa.wdata = d[k];
      step();
    end
    ifa.wdata_valid = 1'b0;
    w_lines[int'(a >> 4)] = 1'b1;
  endtask

  task automatic read_line(logic [15:0] a, bit bp,
                           output logic [LW-1:0][31:0] got,
                           output logic [LW-1:0] lasts,
                           output int t_acc, output int t_first,
                           output int t_last);
    int n;
    int beats;
    got = '0;
    lasts = '0;
    t_first = 0;
    t_last = 0;
    wait_idle("rd_idle");
    ifa.req_valid = 1'b1;
    ifa.req_write = 1'b0;
    ifa.req_addr = a;
    t_acc = cyc;
    step();
    ifa.req_valid = 1'b0;
    n = 0;
    beats = 0;
    while (beats < LW && n < 100) begin
      ifa.rdata_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ifa.rdata_valid && ifa.rdata_ready) begin
        if (beats == 0) t_first = cyc;
        got[beats] = ifa.rdata;
        lasts[beats] = ifa.rdata_last;
        t_last = cyc;
        beats++;
      end
      step();
      n++;
    end
    ifa.rdata_ready = 1'b1;
    chk("rd_beats", beats, LW);
  endtask

  logic [LW-1:0][31:0] d0;
  logic [LW-1:0][31:0] d1;
  logic [LW-1:0][31:0] exp;
  logic [LW-1:0][31:0] got;
  logic [LW-1:0] lasts;
  int ta, tf, tl;

  initial begin
    rst = 1'b1;
    ifa.req_valid = 0; ifa.req_write = 0; ifa.req_addr = '0;
    ifa.wdata_valid = 0; ifa.wdata = '0; ifa.rdata_ready = 1;
    ifz.req_valid = 0; ifz.req_write = 0; ifz.req_addr = '0;
    ifz.wdata_valid = 0; ifz.wdata = '0; ifz.rdata_ready = 1;
    step();
    step();
    rst = 1'b0;
    chk("init_req_ready", ifa.req_ready, 1);
    chk("init_busy", ifa.busy, 0);

    // Write then read, exact timing
    d0[0] = 32'h11111111; d0[1] = 32'h22222222;
    d0[2] = 32'h33333333; d0[3] = 32'h44444444;
    write_line(16'h0040, d0, 1'b0);
    read_line(16'h0040, 1'b0, got, lasts, ta, tf, tl);
    chk("t1_b0", got[0], 32'h11111111);
    chk("t1_b1", got[1], 32'h22222222);
    chk("t1_b2", got[2], 32'h33333333);
    chk("t1_b3", got[3], 32'h44444444);
    chk("t1_lasts", 32'(lasts), 32'h8);
    chk("t1_first", tf - ta, 4);
    chk("t1_lastc", tl - ta, 7);
    chk("t1_ready_cyc", cyc - ta, 8);
    chk("t1_ready", ifa.req_ready, 1);

    // Mid-line read word order
    read_line(16'h0048, 1'b0, got, lasts, ta, tf, tl);
`ifdef MEM_RESP_CRITICAL_WORD_FIRST_EN
    exp[0] = 32'h33333333; exp[1] = 32'h44444444;
    exp[2] = 32'h11111111; exp[3] = 32'h22222222;
`else
    exp = d0;
`endif
    for (int k = 0; k < LW; k++) chk("t2_beat", got[k], exp[k]);
    chk("t2_lasts", 32'(lasts), 32'h8);

    // Backpressure on beat 2
    begin
      int n;
      int beats;
      bit held;
      wait_idle("bp_idle");
      ifa.req_valid = 1; ifa.req_write = 0; ifa.req_addr = 16'h0040;
      step();
      ifa.req_valid = 0;
      n = 0; beats = 0; held = 0;
      while (beats < LW && n < 100) begin
        if (ifa.rdata_valid && beats == 1 && !held) begin
          ifa.rdata_ready = 0;
          for (int h = 0; h < 2; h++) begin
            step();
            chk("bp_data", ifa.rdata, 32'h22222222);
            chk("bp_valid", ifa.rdata_valid, 1);
          end
          ifa.rdata_ready = 1;
          held = 1;
        end
        if (ifa.rdata_valid) beats++;
        step();
        n++;
      end
      chk("bp_beats", beats, LW);
      chk("bp_held", held, 1);
    end

    // Write request while busy is ignored
    wait_idle("busy_idle");
    ifa.req_valid = 1; ifa.req_write = 0; ifa.req_addr = 16'h0040;
    step();
    ifa.req_write = 1;
    ifa.wdata_valid = 1; ifa.wdata = 32'hDEADBEEF;
    chk("busy_rej0", ifa.req_ready, 0);
    step();
    chk("busy_rej1", ifa.req_ready, 0);
    ifa.req_valid = 0; ifa.req_write = 0; ifa.wdata_valid = 0;
    wait_idle("busy_drain");
    read_line(16'h0040, 1'b0, got, lasts, ta, tf, tl);
    for (int k = 0; k < LW; k++) chk("busy_keep", got[k], d0[k]);

    // Reset on read beat 2
    begin
      int n;
      wait_idle("rst_idle");
      ifa.req_valid = 1; ifa.req_write = 0; ifa.req_addr = 16'h0040;
      step();
      ifa.req_valid = 0;
      n = 0;
      while (!(ifa.rdata_valid && ifa.rdata == 32'h22222222) && n < 50) begin
        step();
        n++;
      end
      chk("rst_beat2", ifa.rdata, 32'h22222222);
      rst = 1;
      #1;
      chk("rst_now_valid", ifa.rdata_valid, 0);
      chk("rst_now_data", ifa.rdata, 0);
      chk("rst_now_busy", ifa.busy, 0);
      chk("rst_now_ready", ifa.req_ready, 1);
      step();
      rst = 0;
      chk("rst_rel_ready", ifa.req_ready, 1);
      read_line(16'h0040, 1'b0, got, lasts, ta, tf, tl);
      for (int k = 0; k < LW; k++) chk("rst_reread", got[k], d0[k]);
    end

    // Reset mid write-back keeps stored beats
    for (int k = 0; k < LW; k++) d1[k] = 32'h50505050 + k;
    write_line(16'h0080, d1, 1'b0);
    wait_idle("pw_idle");
    ifa.req_valid = 1; ifa.req_write = 1; ifa.req_addr = 16'h0080;
    step();
    ifa.req_valid = 0;
    ifa.wdata_valid = 1; ifa.wdata = 32'hA0A0A0A0;
    step();
    ifa.wdata = 32'hB1B1B1B1;
    step();
    ifa.wdata_valid = 0;
    rst = 1;
    step();
    rst = 0;
    read_line(16'h0080, 1'b0, got, lasts, ta, tf, tl);
    chk("pw_b0", got[0], 32'hA0A0A0A0);
    chk("pw_b1", got[1], 32'hB1B1B1B1);
    chk("pw_b2", got[2], 32'h50505052);
    chk("pw_b3", got[3], 32'h50505053);

    // Randomised traffic on a small set of lines
    for (int it = 0; it < 40; it++) begin
      logic [15:0] a;
      a = 16'h0200 + 16'(($urandom_range(0, 7) * 16) + ($urandom_range(0, 15) & 12));
      if (!w_lines.exists(int'(a >> 4)) || $urandom_range(0, 9) < 4) begin
        for (int k = 0; k < LW; k++) d1[k] = $urandom;
        write_line(a, d1, 1'b1);
      end else begin
        read_line(a, 1'b1, got, lasts, ta, tf, tl);
      end
    end
    wait_idle("rand_end");

    // Zero-latency instance
    for (int k = 0; k < LW; k++) d1[k] = $urandom;
    ifz.req_valid = 1; ifz.req_write = 1; ifz.req_addr = 16'h0100;
    step();
    ifz.req_valid = 0;
    for (int k = 0; k < LW; k++) begin
      ifz.wdata_valid = 1;
      ifz.wdata = d1[k];
      step();
    end
    ifz.wdata_valid = 0;
    chk("z_idle", ifz.req_ready, 1);
    ifz.req_valid = 1; ifz.req_write = 0; ifz.req_addr = 16'h0100;
    ta = cyc;
    step();
    ifz.req_valid = 0;
    chk("z_first_cyc", cyc - ta, 1);
    chk("z_first_valid", ifz.rdata_valid, 1);
    for (int k = 0; k < LW; k++) begin
      chk("z_beat", ifz.rdata, d1[k]);
      chk("z_last", ifz.rdata_last, k == LW - 1);
      step();
    end
    chk("z_done", ifz.req_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
